// File: rtl/conv_post_accum_pkg.sv
// Shared definitions for the convolution post-accumulation block:
// line-buffer geometry, default widths and FSM state encodings.
package conv_post_accum_pkg;

   localparam int LINE_BUF_LEN = 56;
   localparam int ROW_LEN_DEF  = LINE_BUF_LEN;
   localparam int ACC_W_DEF    = 32;
   localparam int PX_W         = 6;
   localparam int CH_W         = 8;
   localparam int FIFO_DEPTH   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/conv_post_accum_requant_relu_u8.sv
// Combinational requantisation: ReLU, round-half-up right shift, saturate to uint8.
module requant_relu_u8 #(
   parameter int ACC_W = 32
) (
   input  logic [ACC_W-1:0] final_val,
   input  logic [4:0]       shift,
   output logic [7:0]       pixel
);

   // One extra bit so adding the rounding constant to a large positive value cannot wrap.
   logic [ACC_W:0] round_const;
   logic [ACC_W:0] rounded;
   logic [ACC_W:0] shifted;

   always_comb begin
      round_const = '0;
      if (shift != 5'd0) begin
         round_const = (ACC_W+1)'(1) << (shift - 5'd1);
      end
      rounded = {1'b0, final_val} + round_const;
      shifted = rounded >> shift;
      pixel   = 8'd0;
      if (!final_val[ACC_W-1]) begin
         if (shifted > (ACC_W+1)'(255)) begin
            pixel = 8'd255;
         end else begin
            pixel = shifted[7:0];
         end
      end
   end

endmodule

// File: rtl/conv_post_accum.sv
// Row-wise post-accumulation: sums systolic partial sums across channels into a
// row buffer, adds bias, requantises and hands pixels out through a 2-entry FIFO.
module conv_post_accum
   import conv_post_accum_pkg::*;
#(
   parameter int ROW_LEN = ROW_LEN_DEF,
   parameter int ACC_W   = ACC_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  cfg_row_len,
   input  logic [7:0]  cfg_num_ch,
   input  logic [31:0] cfg_bias,
   input  logic [4:0]  cfg_shift,
   input  logic        in_valid,
   input  logic [31:0] psum_3x3,
   input  logic [15:0] product_1x1,
   input  logic [7:0]  identity,
   input  logic        id_en,
   output logic        in_stall,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic        busy,
   output logic        row_done
);

   state_t state_reg, state_next;

   logic [PX_W-1:0]  cfg_row_len_reg;
   logic [CH_W-1:0]  cfg_num_ch_reg;
   logic [31:0]      cfg_bias_reg;
   logic [4:0]       cfg_shift_reg;

   logic [PX_W-1:0]  px_reg;
   logic [CH_W-1:0]  ch_reg;

   logic [ACC_W-1:0] acc_buf [ROW_LEN];
   logic [ACC_W-1:0] buf_rd;
   logic [ACC_W-1:0] beat_sum;
   logic [ACC_W-1:0] id_ext;
   logic [ACC_W-1:0] final_sum;

   logic             s1_valid_reg;
   logic [ACC_W-1:0] s1_data_reg;
   logic [7:0]       s1_pixel;

   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic             wr_ptr_reg;
   logic             rd_ptr_reg;
   logic [1:0]       fifo_count_reg;

   logic             accept;
   logic             last_px;
   logic             last_ch;
   logic             push;
   logic             pop;

   assign last_px = (px_reg == cfg_row_len_reg - 6'd1);
   assign last_ch = (ch_reg == cfg_num_ch_reg - 8'd1);

   assign in_stall = (fifo_count_reg == 2'd2) ||
                     (fifo_count_reg == 2'd1 && s1_valid_reg && !out_ready);
   assign accept   = (state_reg == ST_ACCUM) && in_valid && !in_stall;

   assign out_valid = (fifo_count_reg != 2'd0);
   assign out_data  = fifo_mem[rd_ptr_reg];
   assign pop       = out_valid && out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still take s1.
   assign push      = s1_valid_reg && ((fifo_count_reg != 2'd2) || pop);

   assign busy = (state_reg != ST_IDLE);

   assign id_ext   = id_en ? ACC_W'($signed(identity)) : '0;
   assign beat_sum = ACC_W'($signed(psum_3x3)) + ACC_W'($signed(product_1x1)) + id_ext;
   assign buf_rd   = acc_buf[px_reg];
   // On channel 0 the buffer holds stale data from a previous row, so skip it.
   assign final_sum = ((ch_reg == 8'd0) ? '0 : buf_rd) + beat_sum +
                      ACC_W'($signed(cfg_bias_reg));

   requant_relu_u8 #(.ACC_W(ACC_W)) u_requant (
      .final_val (s1_data_reg),
      .shift     (cfg_shift_reg),
      .pixel     (s1_pixel)
   );

   always_comb begin
      state_next = state_reg;
      row_done   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) state_next = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (accept && last_px && last_ch) state_next = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (!s1_valid_reg && fifo_count_reg == 2'd0) begin
               state_next = ST_IDLE;
               row_done   = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         cfg_row_len_reg <= '0;
         cfg_num_ch_reg  <= '0;
         cfg_bias_reg    <= '0;
         cfg_shift_reg   <= '0;
         px_reg          <= '0;
         ch_reg          <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_IDLE && start) begin
            cfg_row_len_reg <= cfg_row_len;
            cfg_num_ch_reg  <= cfg_num_ch;
            cfg_bias_reg    <= cfg_bias;
            cfg_shift_reg   <= cfg_shift;
            px_reg          <= '0;
            ch_reg          <= '0;
         end else if (accept) begin
            if (last_px) begin
               px_reg <= '0;
               ch_reg <= last_ch ? '0 : ch_reg + 8'd1;
            end else begin
               px_reg <= px_reg + 6'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !last_ch) begin
         acc_buf[px_reg] <= (ch_reg == 8'd0) ? beat_sum : buf_rd + beat_sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s1_data_reg  <= '0;
      end else if (accept && last_ch) begin
         s1_valid_reg <= 1'b1;
         s1_data_reg  <= final_sum;
      end else if (push) begin
         s1_valid_reg <= 1'b0;
      end
   end

   generate
      for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               fifo_mem[gi] <= '0;
            end else if (push && wr_ptr_reg == 1'(gi)) begin
               fifo_mem[gi] <= s1_pixel;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg     <= 1'b0;
         rd_ptr_reg     <= 1'b0;
         fifo_count_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
         if (push && !pop) begin
            fifo_count_reg <= fifo_count_reg + 2'd1;
         end else if (pop && !push) begin
            fifo_count_reg <= fifo_count_reg - 2'd1;
         end
      end
   end

endmodule

// File: doc/conv_post_accum.md
CONV_POST_ACCUM -- requirements
Module: conv_post_accum

Interface
REQ-001 SHALL have parameter ROW_LEN, default 56, meaning the accumulation buffer depth in pixels (one output row).
REQ-002 SHALL have parameter ACC_W, default 32, meaning the accumulator width in bits.
REQ-003 SHALL have ports:
- clk  in  1  the single clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begins a row pass.
- cfg_row_len  in  6  pixels per row, 1..ROW_LEN.
- cfg_num_ch  in  8  input channels, 1..255.
- cfg_bias  in  32  signed bias.
- cfg_shift  in  5  requant right shift.
- in_valid  in  1  beat present from the systolic array.
- psum_3x3  in  32  signed 3x3 partial sum.
- product_1x1  in  16  signed 1x1 product.
- identity  in  8  signed identity pixel.
- id_en  in  1  add identity on this beat.
- in_stall  out  1  upstream must hold; drives pipe_en low.
- out_valid  out  1  output pixel valid.
- out_data  out  8  uint8 output pixel.
- out_ready  in  1  consumer accepts.
- busy  out  1  row pass in progress.
- row_done  out  1  one-cycle pulse at end of pass.

Function
REQ-004 SHALL have states IDLE, ACCUM, FLUSH; IDLE->ACCUM on start; ACCUM->FLUSH after the last pixel of the last channel is accepted; FLUSH->IDLE when stage-1 and FIFO are empty.
REQ-005 SHALL latch all cfg_* on start in IDLE; SHALL ignore start when not IDLE.
REQ-006 SHALL accept a beat iff state==ACCUM && in_valid && !in_stall; SHALL ignore in_valid otherwise.
REQ-007 SHALL compute beat sum = psum_3x3 + sext(product_1x1) + (id_en ? sext(identity) : 0), ACC_W-bit two's-complement wrap.
REQ-008 SHALL keep pixel counter px (0..row_len-1) and channel counter ch (0..num_ch-1); px increments per accepted beat, wraps to 0 and increments ch.
REQ-009 SHALL write buf[px]=sum when ch==0 and buf[px]+=sum when 0<ch<num_ch-1.
REQ-010 When ch==num_ch-1, SHALL form final=buf[px]+sum+cfg_bias (sum+cfg_bias if num_ch==1) and load it into stage-1 register (1-cycle latency).
REQ-011 Requant SHALL be: final<0 -> 0; else (final + (cfg_shift?1<<(cfg_shift-1):0)) >> cfg_shift, saturated to 255.
REQ-012 Stage-1 SHALL push into a 2-entry FIFO feeding out_valid/out_data; pop on out_valid&&out_ready; simultaneous push/pop SHALL keep count.
REQ-013 in_stall SHALL be combinational: (fifo_count==2) || (fifo_count==1 && s1_valid && !out_ready).
REQ-014 Output order SHALL equal pixel order; no pixel lost or duplicated under any out_ready pattern.
REQ-015 row_done SHALL pulse the cycle FLUSH->IDLE; busy=1 in ACCUM and FLUSH.
REQ-016 out_data SHALL be held stable while out_valid && !out_ready.

Reset
REQ-017 rst SHALL clear state to IDLE, counters, stage-1, FIFO count and all outputs to 0 immediately, including mid-pass; buffer contents need no reset.

Structure
REQ-018 ROW_LEN default and state encodings SHALL live in the shared defines include alongside LINE_BUF_LEN.
REQ-019 Requant (REQ-011) SHALL be sub-module requant_relu_u8, combinational.

Verification
REQ-020 row_len=4, num_ch=1, bias=0, shift=0, psum={1,2,3,300}, product=0 -> out {1,2,3,255}, row_done once.
REQ-021 num_ch=3, row_len=2, every beat psum=10, product=-2, id_en=1, identity=-1, bias=5, shift=2 -> final 26 -> out {7,7}.
REQ-022 psum=-100, bias=0 -> out 0 (ReLU); final=6, shift=2 -> out 2 (round 1.5 up).
REQ-023 out_ready=0 for 10 cycles, row_len=4 -> in_stall rises with FIFO full and s1 occupied, no beat accepted, all 4 outputs then emerge in order.
REQ-024 rst asserted mid-ACCUM at ch=1 -> outputs 0 next edge, busy=0; new start, num_ch=1 -> correct fresh results.
REQ-025 start while busy, in_valid in IDLE -> no state change, no output.
